// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / clock-enable generator.
// Each channel emits a registered pulse or square output and a 1-cycle tick at period end.
module clk_div_multi #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned DIV_W   = 8,
   parameter int unsigned DEF_DIV = 4
) (
   input  logic                        clk_100,
   input  logic                        rst_n,
   input  logic [NUM_CH-1:0]           en,
   input  logic [NUM_CH-1:0]           mode,
   input  logic                        div_ld,
   input  logic [$clog2(NUM_CH)-1:0]   ch_sel,
   input  logic [DIV_W-1:0]            div_in,
   input  logic                        sync,
   output logic [NUM_CH-1:0]           clk_out,
   output logic [NUM_CH-1:0]           tick,
   output logic [NUM_CH-1:0]           ld_pend
);

   localparam int unsigned SEL_W = $clog2(NUM_CH);
   localparam logic [DIV_W-1:0] DEF_NZ = (DEF_DIV == 0) ? DIV_W'(1) : DIV_W'(DEF_DIV);

   // A zero divisor behaves as a divide-by-one.
   function automatic logic [DIV_W-1:0] nz(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   logic [DIV_W-1:0] cnt     [NUM_CH];
   logic [DIV_W-1:0] d_act   [NUM_CH];
   logic [DIV_W-1:0] d_pend  [NUM_CH];
   logic [NUM_CH-1:0] idle;

   logic [NUM_CH-1:0] ld_hit;
   logic [NUM_CH-1:0] restart;
   logic [NUM_CH-1:0] tick_nx;
   logic [NUM_CH-1:0] clk_nx;
   logic [DIV_W-1:0]  pend_v  [NUM_CH];
   logic [DIV_W-1:0]  cnt_nx  [NUM_CH];
   logic [DIV_W-1:0]  d_nx    [NUM_CH];

   // Next count, divisor and outputs per channel; outputs use the divisor in force after the edge.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ld_hit[i]  = div_ld && (ch_sel == SEL_W'(i));
         pend_v[i]  = ld_hit[i] ? nz(div_in) : d_pend[i];
         restart[i] = idle[i] || sync || (cnt[i] == d_act[i] - DIV_W'(1));
         cnt_nx[i]  = restart[i] ? '0 : cnt[i] + DIV_W'(1);
         d_nx[i]    = restart[i] ? pend_v[i] : d_act[i];
         tick_nx[i] = (cnt_nx[i] == d_nx[i] - DIV_W'(1));
         clk_nx[i]  = mode[i] ? (cnt_nx[i] >= (d_nx[i] >> 1)) : tick_nx[i];
      end
   end

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            d_act[i]  <= DEF_NZ;
            d_pend[i] <= DEF_NZ;
         end
         idle    <= '1;
         ld_pend <= '0;
         clk_out <= '0;
         tick    <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            d_pend[i] <= pend_v[i];
            if (!en[i]) begin
               // Disabled channel parks; a pending divisor stays pending.
               idle[i]    <= 1'b1;
               cnt[i]     <= '0;
               clk_out[i] <= 1'b0;
               tick[i]    <= 1'b0;
               ld_pend[i] <= ld_pend[i] | ld_hit[i];
            end else begin
               idle[i]    <= 1'b0;
               cnt[i]     <= cnt_nx[i];
               d_act[i]   <= d_nx[i];
               ld_pend[i] <= restart[i] ? 1'b0 : (ld_pend[i] | ld_hit[i]);
               tick[i]    <= tick_nx[i];
               clk_out[i] <= clk_nx[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi.
module tb_clk_div_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] en, mode, clk_out, tick, ld_pend;
   logic       div_ld, sync;
   logic [1:0] ch_sel;
   logic [7:0] div_in;

   logic [2:0] en3, mode3, clk_out3, tick3, ld_pend3;
   logic       div_ld3;
   logic [1:0] ch_sel3;
   logic [7:0] div_in3;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt_t;
   logic [3:0] exp_t, exp_c;

   always #5 clk = ~clk;

   clk_div_multi #(.NUM_CH(4), .DIV_W(8), .DEF_DIV(4)) u_dut (
      .clk_100(clk), .rst_n(rst_n), .en(en), .mode(mode), .div_ld(div_ld),
      .ch_sel(ch_sel), .div_in(div_in), .sync(sync),
      .clk_out(clk_out), .tick(tick), .ld_pend(ld_pend)
   );

   // Three-channel instance so a 2-bit ch_sel can address a nonexistent channel.
   clk_div_multi #(.NUM_CH(3), .DIV_W(8), .DEF_DIV(4)) u_dut3 (
      .clk_100(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .div_ld(div_ld3),
      .ch_sel(ch_sel3), .div_in(div_in3), .sync(1'b0),
      .clk_out(clk_out3), .tick(tick3), .ld_pend(ld_pend3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = '0; mode = '0; div_ld = 1'b0; ch_sel = '0; div_in = '0; sync = 1'b0;
      en3 = '0; mode3 = '0; div_ld3 = 1'b0; ch_sel3 = '0; div_in3 = '0;
      step(); step();
      check("rst_tick", 32'(tick), 0);
      check("rst_clk", 32'(clk_out), 0);
      check("rst_ldp", 32'(ld_pend), 0);

      // ch0 pulse, default divide by 4
      rst_n = 1'b1; en = 4'b0001;
      for (int n = 1; n <= 12; n++) begin
         step();
         check("t1_tick", 32'(tick), (n % 4 == 0) ? 1 : 0);
         check("t1_clk", 32'(clk_out), (n % 4 == 0) ? 1 : 0);
      end

      // ch0 load D=10 at cnt=1: old period completes, then 10-cycle period
      step(); step();
      div_ld = 1'b1; ch_sel = 2'd0; div_in = 8'd10;
      step();
      div_ld = 1'b0;
      check("t3_ldp_set", 32'(ld_pend[0]), 1);
      check("t3_tick_c2", 32'(tick[0]), 0);
      step();
      check("t3_tick_old", 32'(tick[0]), 1);
      check("t3_ldp_hold", 32'(ld_pend[0]), 1);
      step();
      check("t3_ldp_clr", 32'(ld_pend[0]), 0);
      check("t3_tick_c0", 32'(tick[0]), 0);
      cnt_t = 0;
      for (int n = 0; n < 8; n++) begin
         step();
         cnt_t += int'(tick[0]);
      end
      check("t3_quiet", 32'(cnt_t), 0);
      step();
      check("t3_tick_new", 32'(tick[0]), 1);

      // ch1 square D=6 loaded while disabled
      div_ld = 1'b1; ch_sel = 2'd1; div_in = 8'd6;
      step();
      div_ld = 1'b0;
      check("t2_ldp_dis", 32'(ld_pend[1]), 1);
      check("t2_clk_dis", 32'(clk_out[1]), 0);
      en[1] = 1'b1; mode[1] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (k == 0) check("t2_ldp_apply", 32'(ld_pend[1]), 0);
         check("t2_clk", 32'(clk_out[1]), (k % 6 >= 3) ? 1 : 0);
         check("t2_tick", 32'(tick[1]), (k % 6 == 5) ? 1 : 0);
      end

      // ch2: D=0 and D=1 give constant high, then D=255
      div_ld = 1'b1; ch_sel = 2'd2; div_in = 8'd0;
      step();
      div_ld = 1'b0;
      en[2] = 1'b1; mode[2] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         check("t4_d0_tick", 32'(tick[2]), 1);
         check("t4_d0_clk", 32'(clk_out[2]), 1);
      end
      div_ld = 1'b1; div_in = 8'd1;
      step();
      div_ld = 1'b0;
      check("t4_d1_ldp", 32'(ld_pend[2]), 0);
      check("t4_d1_tick", 32'(tick[2]), 1);
      mode[2] = 1'b0; div_ld = 1'b1; div_in = 8'd255;
      step();
      div_ld = 1'b0;
      check("t4_d255_ldp", 32'(ld_pend[2]), 0);
      check("t4_d255_c0", 32'(tick[2]), 0);
      for (int p = 0; p < 2; p++) begin
         cnt_t = 0;
         for (int n = 0; n < 253 + p; n++) begin
            step();
            cnt_t += int'(tick[2]);
         end
         check("t4_d255_quiet", 32'(cnt_t), 0);
         step();
         check("t4_d255_tick", 32'(tick[2]), 1);
         check("t4_d255_clk", 32'(clk_out[2]), 1);
      end

      // sync aligns ch0 D=4, ch1 D=8, ch2 D=5 (loaded on the sync edge)
      div_ld = 1'b1; ch_sel = 2'd0; div_in = 8'd4;
      step();
      ch_sel = 2'd1; div_in = 8'd8;
      step();
      ch_sel = 2'd2; div_in = 8'd5; sync = 1'b1;
      step();
      div_ld = 1'b0; sync = 1'b0;
      check("t5_ldp", 32'(ld_pend), 0);
      check("t5_tick_k0", 32'(tick), 0);
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_t = {1'b0, k % 5 == 4, k % 8 == 7, k % 4 == 3};
         exp_c = {1'b0, k % 5 == 4, k % 8 >= 4, k % 4 == 3};
         check("t5_tick", 32'(tick), 32'(exp_t));
         check("t5_clk", 32'(clk_out), 32'(exp_c));
      end

      // en drop mid-period with a load that stays pending
      en[1] = 1'b0; div_ld = 1'b1; ch_sel = 2'd1; div_in = 8'd3;
      step();
      div_ld = 1'b0;
      check("t6_en_tick", 32'(tick[1]), 0);
      check("t6_en_clk", 32'(clk_out[1]), 0);
      check("t6_en_ldp", 32'(ld_pend[1]), 1);
      step();
      check("t6_en_ldp2", 32'(ld_pend[1]), 1);

      // async reset mid-period
      step();
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_tick", 32'(tick), 0);
      check("t6_rst_clk", 32'(clk_out), 0);
      check("t6_rst_ldp", 32'(ld_pend), 0);
      step();
      rst_n = 1'b1; en = 4'b0100; mode = '0;
      for (int n = 1; n <= 5; n++) begin
         step();
         check("t6_post_rst", 32'(tick), (n == 4) ? 32'h4 : 32'h0);
      end

      // out-of-range ch_sel load on the enable edge must not touch any channel
      en3 = 3'b111; div_ld3 = 1'b1; ch_sel3 = 2'd3; div_in3 = 8'd2;
      step();
      div_ld3 = 1'b0;
      check("t6_oor_ldp", 32'(ld_pend3), 0);
      check("t6_oor_k0", 32'(tick3), 0);
      for (int n = 1; n <= 4; n++) begin
         step();
         check("t6_oor_tick", 32'(tick3), (n == 3) ? 32'h7 : 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
